// File: rtl/lmem_pkg.sv
// Shared constants and types for the local-memory arbiter slice.
package lmem_pkg;

  localparam int LMEM_NUM_BITS = 512;
  localparam int LMEM_ADDR_W   = 6;
  localparam int LMEM_BYTES    = LMEM_NUM_BITS / 8;

  // Host transfer engine states
  typedef enum logic [2:0] {
    H_IDLE  = 3'd0,
    H_FILL  = 3'd1,
    H_WREQ  = 3'd2,
    H_RREQ  = 3'd3,
    H_RWAIT = 3'd4,
    H_DRAIN = 3'd5
  } host_state_e;

  // Requester identities, also the encoding of the round-robin pointer
  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_CMP  = 1'b1;

  // Byte counter width; never zero even for a one-byte line
  function automatic int cnt_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/lmem_arbiter_if.sv
// Host, compute and BRAM-side signal bundle of the local-memory arbiter.
interface lmem_arbiter_if
  import lmem_pkg::*;
#(
  parameter int NUM_BITS = LMEM_NUM_BITS,
  parameter int ADDR_W   = LMEM_ADDR_W
);

  // host byte-serial port
  logic                host_req;
  logic                host_we;
  logic [ADDR_W-1:0]   host_addr;
  logic [7:0]          host_wdata;
  logic                host_wvalid;
  logic [7:0]          host_rdata;
  logic                host_rvalid;
  logic                host_busy;
  logic                host_done;

  // compute chunk port
  logic                cmp_req;
  logic                cmp_we;
  logic [ADDR_W-1:0]   cmp_addr;
  logic [NUM_BITS-1:0] cmp_wdata;
  logic                cmp_gnt;
  logic [NUM_BITS-1:0] cmp_rdata;
  logic                cmp_rvalid;

  // single-port BRAM
  logic                bram_en;
  logic                bram_we;
  logic [ADDR_W-1:0]   bram_addr;
  logic [NUM_BITS-1:0] bram_wdata;
  logic [NUM_BITS-1:0] bram_rdata;

  // arbiter side
  modport slave (
    input  host_req, host_we, host_addr, host_wdata, host_wvalid,
    input  cmp_req, cmp_we, cmp_addr, cmp_wdata,
    input  bram_rdata,
    output host_rdata, host_rvalid, host_busy, host_done,
    output cmp_gnt, cmp_rdata, cmp_rvalid,
    output bram_en, bram_we, bram_addr, bram_wdata
  );

  // requesters plus memory side
  modport master (
    output host_req, host_we, host_addr, host_wdata, host_wvalid,
    output cmp_req, cmp_we, cmp_addr, cmp_wdata,
    output bram_rdata,
    input  host_rdata, host_rvalid, host_busy, host_done,
    input  cmp_gnt, cmp_rdata, cmp_rvalid,
    input  bram_en, bram_we, bram_addr, bram_wdata
  );

endinterface

// File: rtl/lmem_line_buffer.sv
// Line-wide staging buffer: assembles host bytes into a line for writes and
// serializes a fetched line LSB-byte first for reads.
module lmem_line_buffer
  import lmem_pkg::*;
#(
  parameter int NUM_BITS = LMEM_NUM_BITS,
  parameter int CNT_W    = cnt_width(NUM_BITS / 8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                store,
  input  logic [7:0]          byte_in,
  input  logic                load,
  input  logic [NUM_BITS-1:0] line_in,
  input  logic                shift,
  output logic [NUM_BITS-1:0] line,
  output logic [CNT_W-1:0]    cnt
);

  logic [NUM_BITS-1:0] line_r;
  logic [CNT_W-1:0]    cnt_r;

  // Buffer and byte counter update; one control acts per cycle, clear first
  always_ff @(posedge clk) begin
    if (rst) begin
      line_r <= '0;
      cnt_r  <= '0;
    end else if (clear) begin
      cnt_r  <= '0;
    end else if (load) begin
      line_r <= line_in;
      cnt_r  <= '0;
    end else if (store) begin
      line_r[{cnt_r, 3'b000} +: 8] <= byte_in;
      cnt_r  <= cnt_r + CNT_W'(1);
    end else if (shift) begin
      line_r <= {8'h00, line_r[NUM_BITS-1:8]};
      cnt_r  <= cnt_r + CNT_W'(1);
    end else begin
      line_r <= line_r;
      cnt_r  <= cnt_r;
    end
  end

  assign line = line_r;
  assign cnt  = cnt_r;

endmodule

// File: rtl/lmem_arbiter.sv
// Shares a single-port line-wide BRAM between the byte-serial host engine
// and the compute port with a single-cycle round-robin arbiter.
module lmem_arbiter
  import lmem_pkg::*;
#(
  parameter int NUM_BITS = LMEM_NUM_BITS,
  parameter int ADDR_W   = LMEM_ADDR_W
) (
  input logic          clk,
  input logic          rst,
  lmem_arbiter_if.slave bus
);

  localparam int              BYTES    = NUM_BITS / 8;
  localparam int              CNT_W    = cnt_width(BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  host_state_e         state_r;
  logic [ADDR_W-1:0]   haddr_r;
  logic [7:0]          host_rdata_r;
  logic                host_rvalid_r;
  logic                host_done_r;
  logic                host_busy_r;
  logic                cmp_rvalid_r;
  logic                rr_ptr_r;

  logic                host_req_s;
  logic                host_gnt_s;
  logic                cmp_gnt_s;
  logic                contested_s;
  logic                bram_en_s;
  logic                bram_we_s;
  logic [ADDR_W-1:0]   bram_addr_s;
  logic [NUM_BITS-1:0] bram_wdata_s;
  logic [NUM_BITS-1:0] cmp_rdata_s;
  logic                lb_clear_s;
  logic                lb_store_s;
  logic                lb_load_s;
  logic                lb_shift_s;
  logic [NUM_BITS-1:0] lb_line_s;
  logic [CNT_W-1:0]    lb_cnt_s;

  lmem_line_buffer #(
    .NUM_BITS (NUM_BITS),
    .CNT_W    (CNT_W)
  ) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .clear   (lb_clear_s),
    .store   (lb_store_s),
    .byte_in (bus.host_wdata),
    .load    (lb_load_s),
    .line_in (bus.bram_rdata),
    .shift   (lb_shift_s),
    .line    (lb_line_s),
    .cnt     (lb_cnt_s)
  );

  // Line buffer controls follow the host engine state
  always_comb begin
    lb_clear_s = (state_r == H_IDLE)  && bus.host_req;
    lb_store_s = (state_r == H_FILL)  && bus.host_wvalid;
    lb_load_s  = (state_r == H_RWAIT);
    lb_shift_s = (state_r == H_DRAIN) && (lb_cnt_s != LAST_CNT);
  end

  // Round-robin grant: sole requester wins, contest settled by the pointer
  always_comb begin
    host_req_s  = (state_r == H_WREQ) || (state_r == H_RREQ);
    contested_s = host_req_s && bus.cmp_req;
    host_gnt_s  = 1'b0;
    cmp_gnt_s   = 1'b0;
    if (contested_s) begin
      if (rr_ptr_r == REQ_HOST) begin
        host_gnt_s = 1'b1;
      end else begin
        cmp_gnt_s  = 1'b1;
      end
    end else if (host_req_s) begin
      host_gnt_s = 1'b1;
    end else if (bus.cmp_req) begin
      cmp_gnt_s  = 1'b1;
    end else begin
      host_gnt_s = 1'b0;
      cmp_gnt_s  = 1'b0;
    end
  end

  // BRAM controls steered from the cycle's winner
  always_comb begin
    bram_en_s    = 1'b0;
    bram_we_s    = 1'b0;
    bram_addr_s  = '0;
    bram_wdata_s = '0;
    if (host_gnt_s) begin
      bram_en_s    = 1'b1;
      bram_we_s    = (state_r == H_WREQ);
      bram_addr_s  = haddr_r;
      bram_wdata_s = lb_line_s;
    end else if (cmp_gnt_s) begin
      bram_en_s    = 1'b1;
      bram_we_s    = bus.cmp_we;
      bram_addr_s  = bus.cmp_addr;
      bram_wdata_s = bus.cmp_wdata;
    end else begin
      bram_en_s    = 1'b0;
    end
  end

  // Compute read data is the BRAM output, zeroed when not valid
  always_comb begin
    if (cmp_rvalid_r) begin
      cmp_rdata_s = bus.bram_rdata;
    end else begin
      cmp_rdata_s = '0;
    end
  end

  // Pointer flips away from the winner only after a contested grant
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r     <= REQ_HOST;
      cmp_rvalid_r <= 1'b0;
    end else begin
      cmp_rvalid_r <= cmp_gnt_s && !bus.cmp_we;
      if (contested_s) begin
        rr_ptr_r <= host_gnt_s ? REQ_CMP : REQ_HOST;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Host transfer engine with registered host-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= H_IDLE;
      haddr_r       <= '0;
      host_rdata_r  <= 8'h00;
      host_rvalid_r <= 1'b0;
      host_done_r   <= 1'b0;
      host_busy_r   <= 1'b0;
    end else begin
      host_done_r <= 1'b0;
      case (state_r)
        H_IDLE: begin
          if (bus.host_req) begin
            haddr_r     <= bus.host_addr;
            host_busy_r <= 1'b1;
            state_r     <= bus.host_we ? H_FILL : H_RREQ;
          end else begin
            host_busy_r <= 1'b0;
          end
        end
        H_FILL: begin
          if (bus.host_wvalid && (lb_cnt_s == LAST_CNT)) begin
            state_r <= H_WREQ;
          end else begin
            state_r <= H_FILL;
          end
        end
        H_WREQ: begin
          if (host_gnt_s) begin
            state_r     <= H_IDLE;
            host_done_r <= 1'b1;
            host_busy_r <= 1'b0;
          end else begin
            state_r <= H_WREQ;
          end
        end
        H_RREQ: begin
          if (host_gnt_s) begin
            state_r <= H_RWAIT;
          end else begin
            state_r <= H_RREQ;
          end
        end
        H_RWAIT: begin
          // first byte comes straight from the BRAM while the buffer loads
          state_r       <= H_DRAIN;
          host_rvalid_r <= 1'b1;
          host_rdata_r  <= bus.bram_rdata[7:0];
        end
        H_DRAIN: begin
          if (lb_cnt_s == LAST_CNT) begin
            state_r       <= H_IDLE;
            host_rvalid_r <= 1'b0;
            host_rdata_r  <= 8'h00;
            host_done_r   <= 1'b1;
            host_busy_r   <= 1'b0;
          end else begin
            host_rdata_r  <= lb_line_s[15:8];
          end
        end
        default: begin
          state_r       <= H_IDLE;
          host_rvalid_r <= 1'b0;
          host_busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.host_rdata  = host_rdata_r;
  assign bus.host_rvalid = host_rvalid_r;
  assign bus.host_busy   = host_busy_r;
  assign bus.host_done   = host_done_r;
  assign bus.cmp_gnt     = cmp_gnt_s;
  assign bus.cmp_rdata   = cmp_rdata_s;
  assign bus.cmp_rvalid  = cmp_rvalid_r;
  assign bus.bram_en     = bram_en_s;
  assign bus.bram_we     = bram_we_s;
  assign bus.bram_addr   = bram_addr_s;
  assign bus.bram_wdata  = bram_wdata_s;

endmodule
